mult_seq_n: RTL

Parametrised sequential add-shift multiplier, the WIDTH-generic successor of the lab 5 8-bit multiplier datapath. It captures both operands on a Start pulse and retires one multiplier bit per clock through a (WIDTH+1)-bit adder/subtractor. It returns a 2·WIDTH-bit product with a one-cycle Done pulse, in either two's-complement or unsigned mode. It sits behind the button synchronisers and drives the A/B hex displays through the existing HexDriver instances.

---
 rtl/mult_seq_n_if.sv | 42 ++++
 rtl/mult_seq_n.sv | 104 ++++++++++
 2 files changed

// File: rtl/mult_seq_n_if.sv
// mult_seq_n request/response bundle.
// Operands and mode in, status and live registers out.
interface mult_seq_n_if #(
  parameter int WIDTH = 8
);
  logic                 Start;
  logic                 Signed_Mode;
  logic [WIDTH-1:0]     Multiplicand;
  logic [WIDTH-1:0]     Multiplier;
  logic                 Busy;
  logic                 Done;
  logic [WIDTH-1:0]     Aval;
  logic [WIDTH-1:0]     Bval;
  logic [2*WIDTH-1:0]   Product;
  logic                 X;

  modport master (
    output Start,
    output Signed_Mode,
    output Multiplicand,
    output Multiplier,
    input  Busy,
    input  Done,
    input  Aval,
    input  Bval,
    input  Product,
    input  X
  );

  modport slave (
    input  Start,
    input  Signed_Mode,
    input  Multiplicand,
    input  Multiplier,
    output Busy,
    output Done,
    output Aval,
    output Bval,
    output Product,
    output X
  );
endinterface

// File: rtl/mult_seq_n.sv
// Sequential add-shift multiplier, one multiplier bit per clock,
// signed (two's-complement) or unsigned, 2*WIDTH-bit product.
module mult_seq_n #(
  parameter int WIDTH = 8
) (
  input  logic        Clk,
  input  logic        Reset_n,
  mult_seq_n_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_s;
  logic             r_x;
  logic             r_mode;
  logic             r_busy;
  logic             r_done;
  logic [CW-1:0]    r_cnt;

  logic             w_last;
  logic [WIDTH:0]   w_ext_a;
  logic [WIDTH:0]   w_ext_s;
  logic [WIDTH:0]   w_opnd;
  logic [WIDTH:0]   w_sum;

  // Last signed step subtracts S: the multiplier MSB has negative weight.
  always_comb begin
    w_last  = (r_cnt == LAST);
    w_ext_a = {r_mode & r_a[WIDTH-1], r_a};
    w_ext_s = {r_mode & r_s[WIDTH-1], r_s};
    w_opnd  = '0;
    if (r_b[0]) begin
      w_opnd = (w_last && r_mode) ? -w_ext_s : w_ext_s;
    end
    w_sum = w_ext_a + w_opnd;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_x     <= 1'b0;
      r_mode  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.Start) begin
            r_a     <= '0;
            r_x     <= 1'b0;
            r_b     <= bus.Multiplier;
            r_s     <= bus.Multiplicand;
            r_mode  <= bus.Signed_Mode;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= CALC;
          end
        end
        CALC: begin
          r_x   <= w_sum[WIDTH];
          r_a   <= {w_sum[WIDTH], w_sum[WIDTH-1:1]};
          r_b   <= {w_sum[0], r_b[WIDTH-1:1]};
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.Busy    = r_busy;
  assign bus.Done    = r_done;
  assign bus.Aval    = r_a;
  assign bus.Bval    = r_b;
  assign bus.Product = {r_a, r_b};
  assign bus.X       = r_x;

endmodule
